// File: rtl/matrix_pkg.sv
// matrix_pkg -- shared geometry, scan state encoding and row-slice helper for matrix_scan.
// Revision 1.0
`default_nettype none

package matrix_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  function automatic logic [COLS-1:0] row_cols(input logic [ROWS*COLS-1:0] img,
                                               input logic [ROW_W-1:0]     r);
    return img[COLS*r +: COLS];
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_scan_timer.sv
// matrix_scan_timer -- per-state cycle counter; done_o flags the last cycle of the state.
// Revision 1.0
`default_nettype none

module matrix_scan_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] last_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = load_i ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == last_i);

endmodule

`default_nettype wire

// File: rtl/matrix_scan.sv
// matrix_scan -- 4x4 LED matrix row scanner with dead-time blanking between rows.
// Revision 1.0
`default_nettype none

module matrix_scan
  import matrix_pkg::*;
#(
  parameter int CLK_DIV     = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] matrix,
  output logic [ROWS-1:0]      row_n,
  output logic [COLS-1:0]      col,
  output logic                 frame_tick
);

  localparam int MAXLEN = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(DEAD_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [ROWS*COLS-1:0]   snap_q, snap_d;
  logic [ROWS-1:0]        row_n_q, row_n_d;
  logic [COLS-1:0]        col_q, col_d;
  logic                   tick_q, tick_d;

  logic                   done;
  logic                   load;
  logic [CW-1:0]          last;

  assign last = (state_q == SHOW) ? SHOW_LAST : BLANK_LAST;
  // Holding the counter in load while disabled makes re-enable look exactly like reset release.
  assign load = done | ~enable;

  matrix_scan_timer #(
    .CW(CW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .last_i (last),
    .done_o (done)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    snap_d  = snap_q;
    row_n_d = '1;
    col_d   = '0;
    tick_d  = 1'b0;

    if (!enable) begin
      state_d = BLANK;
      row_d   = ROW_W'(ROWS - 1);
    end else if (done) begin
      if (state_q == SHOW) begin
        state_d = BLANK;
      end else begin
        state_d = SHOW;
        row_d   = row_q + ROW_W'(1);
        if (row_q == ROW_W'(ROWS - 1)) begin
          snap_d = matrix;
        end
      end
    end

    // Outputs are computed from next state so the registered drivers line up with state_q.
    if (state_d == SHOW) begin
      row_n_d[row_d] = 1'b0;
      col_d          = row_cols(snap_d, row_d);
      tick_d         = (state_q == BLANK) && (row_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BLANK;
      row_q   <= ROW_W'(ROWS - 1);
      snap_q  <= '0;
      row_n_q <= '1;
      col_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      snap_q  <= snap_d;
      row_n_q <= row_n_d;
      col_q   <= col_d;
      tick_q  <= tick_d;
    end
  end

  assign row_n      = row_n_q;
  assign col        = col_q;
  assign frame_tick = tick_q;

endmodule

`default_nettype wire
